// File: rtl/serial_add_pkg.sv
// Shared sizing constants and FSM state encoding for the nibble-serial adder.
package serial_add_pkg;

   localparam int WIDTH   = 32;
   localparam int SLICE   = 4;
   localparam int NIBBLES = WIDTH / SLICE;
   localparam int IDX_W   = $clog2(NIBBLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/add4_slice.sv
// Stateless SLICE-bit ripple adder; the only arithmetic element in the datapath.
module add4_slice
   import serial_add_pkg::*;
(
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};

endmodule

// File: rtl/serial_add_sequencer.sv
// 32-bit add/subtract computed one nibble per cycle through a single shared slice.
module serial_add_sequencer
   import serial_add_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             m,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   state_t           state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic             carry_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] bp_reg;     // b already conditioned for the mode (b or ~b)
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;
   logic             ovf_reg;
   logic             busy_reg;
   logic             done_reg;

   logic [SLICE-1:0] a_nib  [NIBBLES];
   logic [SLICE-1:0] bp_nib [NIBBLES];
   logic [WIDTH-1:0] sum_next;
   logic [SLICE-1:0] slice_s;
   logic             slice_co;
   logic             last_nib;

   // Split operands into nibbles and merge the slice result into the active nibble.
   for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi]  = a_reg[gi*SLICE +: SLICE];
      assign bp_nib[gi] = bp_reg[gi*SLICE +: SLICE];
      assign sum_next[gi*SLICE +: SLICE] =
         (idx_reg == IDX_W'(gi)) ? slice_s : sum_reg[gi*SLICE +: SLICE];
   end

   add4_slice u_slice (
      .a  (a_nib[idx_reg]),
      .b  (bp_nib[idx_reg]),
      .ci (carry_reg),
      .s  (slice_s),
      .co (slice_co)
   );

   assign last_nib = (idx_reg == IDX_W'(NIBBLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         bp_reg    <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  a_reg     <= a;
                  bp_reg    <= m ? b : ~b;
                  carry_reg <= m ? cin : 1'b1;
                  idx_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_RUN;
               end else begin
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sum_reg   <= sum_next;
               carry_reg <= slice_co;
               idx_reg   <= idx_reg + 1'b1;
               if (last_nib) begin
                  cout_reg  <= slice_co;
                  ovf_reg   <= (a_reg[WIDTH-1] == bp_reg[WIDTH-1]) &&
                               (slice_s[SLICE-1] != a_reg[WIDTH-1]);
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= ST_DONE;
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign sum  = sum_reg;
   assign cout = cout_reg;
   assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized bench for serial_add_sequencer against an arithmetic reference model.
module tb_serial_add_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        m;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_sum;
   logic        exp_cout;
   logic        exp_ovf;

   serial_add_sequencer dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .m     (m),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: signed range test for overflow, unsigned magnitude for carry/borrow.
   function automatic logic [33:0] model(input logic mm, input logic [31:0] aa,
                                         input logic [31:0] bb, input logic cc);
      longint sa, sb, sres, ua, ub, ures;
      logic [31:0] s;
      logic co, ov;
      sa = longint'($signed(aa));
      sb = longint'($signed(bb));
      ua = longint'(aa);
      ub = longint'(bb);
      if (mm) begin
         sres = sa + sb + longint'(cc);
         ures = ua + ub + longint'(cc);
         co   = (ures > 64'sh0000_0000_FFFF_FFFF);
      end else begin
         sres = sa - sb;
         ures = ua - ub;
         co   = (ua >= ub);
      end
      s  = ures[31:0];
      ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      return {ov, co, s};
   endfunction

   // Issue one operation at a negedge while ready; scramble inputs during RUN.
   task automatic run_op(input logic mm, input logic [31:0] aa, input logic [31:0] bb,
                         input logic cc, input bit b2b);
      logic [33:0] e;
      e = model(mm, aa, bb, cc);
      start = 1'b1; m = mm; a = aa; b = bb; cin = cc;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("busy_run", busy, 1);
         check("done_run", done, 0);
         a = $urandom; b = $urandom; m = 1'($urandom); cin = 1'($urandom);
         start = b2b ? 1'b1 : 1'($urandom);
      end
      @(negedge clk);
      exp_sum  = e[31:0];
      exp_cout = e[32];
      exp_ovf  = e[33];
      check("done_pulse", done, 1);
      check("busy_done", busy, 0);
      check("sum", sum, exp_sum);
      check("cout", cout, exp_cout);
      check("ovf", ovf, exp_ovf);
      $display("op m=%0d a=%08h b=%08h cin=%0d -> sum=%08h cout=%0d ovf=%0d (exp %08h %0d %0d)",
               mm, aa, bb, cc, sum, cout, ovf, exp_sum, exp_cout, exp_ovf);
   endtask

   task automatic idle_check();
      start = 1'b0;
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("hold_sum", sum, exp_sum);
      check("hold_cout", cout, exp_cout);
      check("hold_ovf", ovf, exp_ovf);
   endtask

   logic        dm   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [31:0] da   [6] = '{32'h3, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h5, 32'h7, 32'h8000_0000};
   logic [31:0] db   [6] = '{32'h3, 32'h0, 32'h1, 32'h7, 32'h5, 32'h1};
   logic        dcin [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      bit seen_done;
      logic [31:0] ra, rb;
      rst = 1'b1; start = 1'b0; m = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
      idle_check();

      for (int i = 0; i < 6; i++) begin
         run_op(dm[i], da[i], db[i], dcin[i], 1'b0);
         idle_check();
      end

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 5 == 0) ra = {ra[31], {31{ra[0]}}};
         if (i % 7 == 0) rb = ra;
         run_op(1'($urandom), ra, rb, 1'($urandom), 1'b0);
         idle_check();
      end

      // start held high: each DONE cycle immediately launches the next operation
      for (int i = 0; i < 4; i++)
         run_op(1'($urandom), $urandom, $urandom, 1'($urandom), 1'b1);
      idle_check();

      // abort mid-run once idx has reached 4, with start also asserted
      start = 1'b1; m = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sum", sum, 0);
      check("abort_cout", cout, 0);
      check("abort_ovf", ovf, 0);
      rst = 1'b0; start = 1'b0;
      seen_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("abort_no_done", seen_done, 0);
      $display("op reset mid-run -> busy=%0d done=%0d sum=%08h", busy, done, sum);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 start  input  1  request to begin one 32-bit operation; sampled only when ready.
REQ-005 m  input  1  mode: 1 = add (a+b+cin), 0 = subtract (a-b); sampled with start.
REQ-006 a  input  32  operand A; sampled with start.
REQ-007 b  input  32  operand B; sampled with start.
REQ-008 cin  input  1  carry-in for add mode; ignored in subtract mode; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress (RUN state).
REQ-010 done  output  1  one-cycle pulse marking result valid.
REQ-011 sum  output  32  result; holds the last completed value.
REQ-012 cout  output  1  final carry out of bit 31.
REQ-013 ovf  output  1  signed two's-complement overflow of the last operation.

Function
REQ-014 The block SHALL compute the 32-bit result nibble-serially: one shared 4-bit adder slice processes one nibble per cycle, LSB nibble first, 8 cycles per operation.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 ready is defined as state IDLE or DONE; start is accepted only when ready.
REQ-017 IDLE: start=1 latches a, b, m, cin, clears nibble index to 0, and goes to RUN; start=0 stays in IDLE.
REQ-018 RUN: each cycle the slice adds nibble[idx] of A and B' with the carry register, writes the 4-bit result into sum nibble[idx], updates the carry register, and increments idx.
REQ-019 RUN: after the cycle with idx=7 the FSM SHALL go to DONE; idx wraps 7->0 and is never used out of range.
REQ-020 DONE: done=1 for exactly that cycle; start=1 re-enters RUN with new operands (back-to-back); otherwise go to IDLE.
REQ-021 Latency: a start accepted at edge k SHALL give done=1 in the cycle after edge k+8; busy=1 during cycles after edges k..k+7.
REQ-022 Add mode SHALL use B'=b and initial carry=cin; subtract mode SHALL use B'=~b and initial carry=1.
REQ-023 cout SHALL be the carry out of nibble 7; ovf = (a[31]==B'[31]) and (sum[31]!=a[31]); both update with the final nibble.
REQ-024 start while busy=1 SHALL be ignored; operands and result are not disturbed.
REQ-025 a, b, m and cin changing during RUN SHALL have no effect on the result.
REQ-026 sum, cout and ovf SHALL hold their values from DONE until the final nibble of the next operation; intermediate nibbles of sum may update during RUN.
REQ-027 All arithmetic is modulo 2^32; the carry out of nibble 7 goes only to cout.

Reset
REQ-028 rst=1 SHALL force state IDLE, idx=0, carry register=0, busy=0, done=0, sum=0, cout=0 and ovf=0 on the next posedge clk.
REQ-029 rst during RUN or DONE SHALL abort the operation with no done pulse; rst takes priority over start in the same cycle.

Structure
REQ-030 A shared package serial_add_pkg SHALL hold WIDTH=32, SLICE=4, NIBBLES=8 and the FSM state enumeration.
REQ-031 The 4-bit adder SHALL be a separate combinational sub-module add4_slice (a, b, ci -> s, co), instantiated exactly once.
REQ-032 All registers SHALL live in serial_add_sequencer; add4_slice has no state.

Verification
REQ-033 Add: m=1, a=0x0000_0003, b=0x0000_0003, cin=0 -> done 9 cycles after start, sum=0x0000_0006, cout=0, ovf=0.
REQ-034 Carry chain: m=1, a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, ovf=0.
REQ-035 Signed overflow: m=1, a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, ovf=1.
REQ-036 Subtract: m=0, a=0x0000_0005, b=0x0000_0007 -> sum=0xFFFF_FFFE, cout=0, ovf=0; with a=7, b=5 -> sum=0x0000_0002, cout=1.
REQ-037 Back-to-back and ignored start: start held high continuously -> done pulses every 9 cycles with busy=1 for 8 cycles between; extra starts during RUN change nothing.
REQ-038 Reset mid-run: rst=1 at RUN idx=4 -> next cycle busy=0, done=0, sum=0, and no done pulse follows.
